alu_serial_exec: RTL and testbench
==================================

// Module: alu_serial_exec
// PURPOSE
//  Multi-cycle execution unit that consumes the 4-bit ALU control code
//  (0010 ADD, 0110 SUB, 0000 AND, 0001 OR) from ALU control decode.
//  Processes operands DIGIT bits per cycle, LSB first.
//  Returns result, zero flag (used for BEQ) and carry over a valid/ready handshake.
//  Sits between decode/register-read and writeback in the multi-cycle datapath variant.
// PARAMETERS
//  WIDTH  32  operand/result width in bits
//  DIGIT  8   bits processed per cycle; WIDTH % DIGIT == 0 required; BEATS = WIDTH/DIGIT
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      asynchronous active-low reset
//  in_valid   in   1      operation request valid
//  in_ready   out  1      unit can accept a request
//  ctrl       in   4      ALU control code
//  op_a       in   WIDTH  operand A
//  op_b       in   WIDTH  operand B
//  out_valid  out  1      result valid
//  out_ready  in   1      downstream accepts result
//  result     out  WIDTH  operation result
//  zero       out  1      result == 0
//  carry      out  1      carry out of MSB (ADD/SUB only, else 0)
//  illegal    out  1      ctrl was not one of the four legal codes
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE, in_ready=1, out_valid=0, result=0,
//    zero=0, carry=0, illegal=0, beat counter=0. Reset mid-operation aborts
//    the operation; no partial result is ever presented.
//  - FSM: IDLE -> BUSY on in_valid&&in_ready; BUSY -> DONE after BEATS cycles;
//    DONE -> IDLE on out_valid&&out_ready.
//  - in_ready=1 only in IDLE; out_valid=1 only in DONE. There is no overlap
//    between accepting a new request and presenting a result.
//  - Accept edge: latch ctrl, op_a, and op_b. For SUB, latch ~op_b and set
//    carry-in=1. Otherwise carry-in=0.
//  - BUSY: each cycle, compute DIGIT LSBs (add with running carry, or bitwise
//    AND/OR). Shift operands right by DIGIT. Shift partial result in from the
//    MSB end. Increment counter.
//  - After the BEATS-th BUSY edge, enter DONE. out_valid rises BEATS edges
//    after the accept edge (latency = BEATS cycles).
//  - result/zero/carry/illegal are stable throughout DONE; hold under
//    backpressure (out_ready=0) indefinitely.
//  - ADD/SUB are modulo 2^WIDTH. carry = final carry out. For SUB,
//    carry=1 means no borrow (op_a >= op_b unsigned).
//  - Illegal ctrl (any other code): still takes BEATS cycles; result=0, zero=1,
//    carry=0, illegal=1.
//  - in_valid during BUSY/DONE is ignored (not captured). ctrl/op_* may change
//    freely after the accept edge.
//  - DIGIT == WIDTH is legal: BEATS=1, single BUSY cycle.
// TESTING (WIDTH=32, DIGIT=8, BEATS=4)
//  1. ADD 0x0000_00FF + 0x0000_0001 -> out_valid 4 cycles after accept;
//     result=0x0000_0100, zero=0, carry=0, illegal=0.
//  2. SUB 5 - 5 -> result=0, zero=1, carry=1.
//     SUB 3 - 5 -> result=0xFFFF_FFFE, carry=0.
//  3. ADD 0xFFFF_FFFF + 1 -> result=0, zero=1, carry=1.
//     AND 0xF0F0_F0F0 & 0xFF00_FF00 -> 0xF000_F000.
//     OR 0x0F00_00F0 | 0x00F0_000F -> 0x0FF0_00FF.
//  4. Hold out_ready=0 for 10 cycles in DONE -> outputs stable, in_ready=0.
//     out_ready=1 -> next cycle in_ready=1. Back-to-back request is accepted
//     on that cycle.
//  5. Assert rst_n=0 during beat 2 of an ADD -> out_valid=0 and in_ready=1
//     immediately. A new request after release yields a correct result.
//  6. ctrl=4'b1111, in_valid toggling during BUSY -> illegal=1, result=0,
//     zero=1, carry=0. Exactly one result per accepted request.

Source files
------------

// File: rtl/alu_serial_exec_if.sv
// Request/response bundle for the digit-serial ALU: operation request in, result/flags out.
interface alu_serial_exec_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       ctrl;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             carry;
  logic             illegal;

  modport master (
    output in_valid, ctrl, op_a, op_b, out_ready,
    input  in_ready, out_valid, result, zero, carry, illegal
  );

  modport slave (
    input  in_valid, ctrl, op_a, op_b, out_ready,
    output in_ready, out_valid, result, zero, carry, illegal
  );
endinterface

// File: rtl/alu_serial_exec.sv
// Multi-cycle ALU: ADD/SUB/AND/OR over DIGIT bits per cycle, LSB first,
// returning result, zero, carry and illegal over a valid/ready handshake.
module alu_serial_exec #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DIGIT = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  alu_serial_exec_if.slave   bus
);
  localparam int unsigned BEATS = WIDTH / DIGIT;
  localparam int unsigned CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned DW    = DIGIT + 1;

  localparam logic [3:0] CTRL_AND = 4'b0000;
  localparam logic [3:0] CTRL_OR  = 4'b0001;
  localparam logic [3:0] CTRL_ADD = 4'b0010;
  localparam logic [3:0] CTRL_SUB = 4'b0110;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [3:0]       ctrl_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic             cy_q;

  logic [DW-1:0]    sum;
  logic [DIGIT-1:0] dig;
  logic [WIDTH-1:0] res_nxt;
  logic             legal;
  logic             arith;

  // One digit of the current operation; partial result enters from the MSB end
  always_comb begin
    sum     = '0;
    dig     = '0;
    res_nxt = '0;
    arith   = (ctrl_q == CTRL_ADD) || (ctrl_q == CTRL_SUB);
    legal   = arith || (ctrl_q == CTRL_AND) || (ctrl_q == CTRL_OR);
    sum     = DW'(a_q[DIGIT-1:0]) + DW'(b_q[DIGIT-1:0]) + DW'(cy_q);
    case (ctrl_q)
      CTRL_AND: dig = a_q[DIGIT-1:0] & b_q[DIGIT-1:0];
      CTRL_OR:  dig = a_q[DIGIT-1:0] | b_q[DIGIT-1:0];
      default:  dig = sum[DIGIT-1:0];
    endcase
    res_nxt = (res_q >> DIGIT) | (WIDTH'(dig) << (WIDTH - DIGIT));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      ctrl_q        <= '0;
      a_q           <= '0;
      b_q           <= '0;
      res_q         <= '0;
      cy_q          <= 1'b0;
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
      bus.result    <= '0;
      bus.zero      <= 1'b0;
      bus.carry     <= 1'b0;
      bus.illegal   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            // Subtraction runs as A + ~B + 1 so carry-out means "no borrow"
            ctrl_q       <= bus.ctrl;
            a_q          <= bus.op_a;
            b_q          <= (bus.ctrl == CTRL_SUB) ? ~bus.op_b : bus.op_b;
            cy_q         <= (bus.ctrl == CTRL_SUB);
            res_q        <= '0;
            cnt          <= '0;
            bus.in_ready <= 1'b0;
            state        <= BUSY;
          end
        end
        BUSY: begin
          a_q   <= a_q >> DIGIT;
          b_q   <= b_q >> DIGIT;
          res_q <= res_nxt;
          cy_q  <= sum[DIGIT];
          if (cnt == CW'(BEATS - 1)) begin
            cnt           <= '0;
            state         <= DONE;
            bus.out_valid <= 1'b1;
            bus.illegal   <= ~legal;
            bus.result    <= legal ? res_nxt : '0;
            bus.zero      <= legal ? (res_nxt == '0) : 1'b1;
            bus.carry     <= arith & sum[DIGIT];
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            bus.in_ready  <= 1'b1;
            state         <= IDLE;
          end
        end
        default: begin
          state         <= IDLE;
          bus.in_ready  <= 1'b1;
          bus.out_valid <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_alu_serial_exec.sv
// Scoreboard bench for alu_serial_exec: directed requests push expected results,
// a negedge monitor pops and compares every completed output transfer.
module tb_alu_serial_exec;
  localparam int unsigned WIDTH = 32;
  localparam int unsigned DIGIT = 8;

  localparam logic [3:0] ADD = 4'b0010;
  localparam logic [3:0] SUB = 4'b0110;
  localparam logic [3:0] AND = 4'b0000;
  localparam logic [3:0] OR  = 4'b0001;

  typedef struct {
    logic [31:0] res;
    logic        z;
    logic        c;
    logic        il;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;

  alu_serial_exec_if #(.WIDTH(WIDTH)) bus ();

  alu_serial_exec #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_sent   = 0;
  int   n_recv   = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // Output monitor: a transfer completes on the next posedge when valid && ready
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      n_recv++;
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL spurious_out: got result %0h with no request outstanding", bus.result);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result",  64'(bus.result),  64'(e.res));
        check("zero",    64'(bus.zero),    64'(e.z));
        check("carry",   64'(bus.carry),   64'(e.c));
        check("illegal", 64'(bus.illegal), 64'(e.il));
      end
    end
  end

  // Called at posedge+1; returns at accept edge+1 with random junk on the request bus
  task automatic send(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] res, input logic z, input logic cy, input logic il);
    exp_t e;
    int   n;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("accept_ready", 64'(bus.in_ready), 64'd1);
    e.res = res; e.z = z; e.c = cy; e.il = il;
    bus.ctrl     = c;
    bus.op_a     = a;
    bus.op_b     = b;
    bus.in_valid = 1'b1;
    sb.push_back(e);
    n_sent++;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.ctrl     = 4'($urandom);
    bus.op_a     = $urandom;
    bus.op_b     = $urandom;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.ctrl      = '0;
    bus.op_a      = '0;
    bus.op_b      = '0;
    bus.out_ready = 1'b1;
    #23;
    check("rst_in_ready",  64'(bus.in_ready),  64'd1);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_outputs",   64'({bus.result, bus.zero, bus.carry, bus.illegal}), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Latency: out_valid rises four edges after the accept edge
    send(ADD, 32'h0000_00FF, 32'h0000_0001, 32'h0000_0100, 1'b0, 1'b0, 1'b0);
    lat = 0;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) begin lat = i; break; end
    end
    check("latency", 64'(lat), 64'd4);
    drain();

    send(SUB, 32'd5, 32'd5, 32'h0000_0000, 1'b1, 1'b1, 1'b0);
    send(SUB, 32'd3, 32'd5, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
    send(ADD, 32'hFFFF_FFFF, 32'd1, 32'h0000_0000, 1'b1, 1'b1, 1'b0);
    send(AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1'b0, 1'b0);
    send(OR,  32'h0F00_00F0, 32'h00F0_000F, 32'h0FF0_00FF, 1'b0, 1'b0, 1'b0);
    send(SUB, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0);
    drain();

    // Backpressure: hold ten cycles in DONE, then release and issue back-to-back
    bus.out_ready = 1'b0;
    send(ADD, 32'h1234_5678, 32'h1111_1111, 32'h2345_6789, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20 && !bus.out_valid; i++) begin
      @(posedge clk); #1;
    end
    check("bp_valid", 64'(bus.out_valid), 64'd1);
    for (int i = 0; i < 10; i++) begin
      check("bp_hold", 64'({bus.out_valid, bus.in_ready, bus.result, bus.zero, bus.carry, bus.illegal}),
            64'({1'b1, 1'b0, 32'h2345_6789, 1'b0, 1'b0, 1'b0}));
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("release_in_ready", 64'(bus.in_ready), 64'd1);
    send(SUB, 32'h0000_0010, 32'h0000_0001, 32'h0000_000F, 1'b0, 1'b1, 1'b0);
    check("b2b_accepted", 64'(bus.in_ready), 64'd0);
    drain();

    // Reset during beat 2 aborts the ADD without ever presenting it
    send(ADD, 32'h0000_0001, 32'h0000_0002, 32'h0000_0003, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", 64'(bus.out_valid), 64'd0);
    check("abort_in_ready",  64'(bus.in_ready),  64'd1);
    sb.delete();
    n_sent--;
    #10;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(ADD, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1, 1'b1, 1'b0);
    drain();

    // Illegal code with in_valid chattering while busy/done
    bus.out_ready = 1'b0;
    send(4'b1111, 32'h0000_0123, 32'h0000_0456, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      bus.in_valid = ~bus.in_valid;
      bus.ctrl     = ADD;
      @(posedge clk); #1;
      check("busy_in_ready", 64'(bus.in_ready), 64'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    drain();
    repeat (8) @(posedge clk);
    #1;
    check("one_result_per_req", 64'(n_recv), 64'(n_sent));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
